pe_psum_accumulator: RTL and testbench

Consumes the signed products emitted by the PE multiplier and reduces them into one partial sum (psum) per filter window. After the last product of a window it adds an incoming psum (from the psum scratchpad or the vertical neighbour PE) and presents the saturated result downstream on a valid/ready handshake. It sits between the PE multiplier and the psum scratchpad / output FIFO.

---
 rtl/pe_psum_accumulator.sv | 137 +++++++++++++
 tb/tb_pe_psum_accumulator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_psum_accumulator.sv
// Partial-sum accumulator for one PE: reduces a window of signed products, adds the
// incoming psum, and hands the saturated result downstream on a valid/ready handshake.
module pe_psum_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [CNT_WIDTH-1:0]          filter_len,
  input  logic                          prod_valid,
  input  logic signed [2*DATA_WIDTH-1:0] product,
  input  logic                          psum_in_valid,
  input  logic signed [PSUM_WIDTH-1:0]  psum_in,
  output logic                          psum_in_ready,
  output logic                          psum_out_valid,
  output logic signed [PSUM_WIDTH-1:0]  psum_out,
  input  logic                          psum_out_ready,
  output logic                          busy,
  output logic                          ovf,
  output logic [1:0]                    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Both readies/valids driven here are pure decodes of the state register.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_PSUM  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic signed [PSUM_WIDTH-1:0] PSUM_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic signed [PSUM_WIDTH-1:0] PSUM_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]         CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                        state, state_next;
  logic signed [PSUM_WIDTH-1:0]  acc, acc_next;
  logic [CNT_WIDTH-1:0]          cnt, cnt_next;
  logic [CNT_WIDTH-1:0]          len, len_next;
  logic                          ovf_reg, ovf_next;

  logic signed [PSUM_WIDTH-1:0]  prod_ext;
  logic signed [PSUM_WIDTH-1:0]  addend;
  logic signed [PSUM_WIDTH:0]    sum_wide;
  logic signed [PSUM_WIDTH-1:0]  sum_sat;
  logic                          sum_clamped;

  assign prod_ext = PSUM_WIDTH'(product);

  // One shared adder: products feed it in ACCUM, the incoming psum in PSUM.
  assign addend   = (state == S_ACCUM) ? prod_ext : psum_in;
  assign sum_wide = {acc[PSUM_WIDTH-1], acc} + {addend[PSUM_WIDTH-1], addend};

  // The top two bits of the widened sum disagree exactly when the true result is out of range.
  always_comb begin
    sum_clamped = 1'b0;
    sum_sat     = sum_wide[PSUM_WIDTH-1:0];
    if (sum_wide[PSUM_WIDTH] != sum_wide[PSUM_WIDTH-1]) begin
      sum_clamped = 1'b1;
      sum_sat     = sum_wide[PSUM_WIDTH] ? PSUM_MIN : PSUM_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      acc     <= '0;
      cnt     <= '0;
      len     <= '0;
      ovf_reg <= 1'b0;
    end else begin
      state   <= state_next;
      acc     <= acc_next;
      cnt     <= cnt_next;
      len     <= len_next;
      ovf_reg <= ovf_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    len_next   = len;
    ovf_next   = ovf_reg;
    case (state)
      S_IDLE: begin
        if (start) begin
          acc_next = '0;
          ovf_next = 1'b0;
          if (filter_len != '0) begin
            cnt_next   = '0;
            len_next   = filter_len;
            state_next = S_ACCUM;
          end else begin
            state_next = S_PSUM;
          end
        end
      end
      S_ACCUM: begin
        if (prod_valid) begin
          acc_next = sum_sat;
          ovf_next = ovf_reg | sum_clamped;
          cnt_next = cnt + CNT_ONE;
          if (cnt == len - CNT_ONE) begin
            state_next = S_PSUM;
          end
        end
      end
      S_PSUM: begin
        if (psum_in_valid) begin
          acc_next   = sum_sat;
          ovf_next   = ovf_reg | sum_clamped;
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        // A start arriving with the handshake is dropped; it must be reasserted in IDLE.
        if (psum_out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign psum_in_ready  = (state == S_PSUM);
  assign psum_out_valid = (state == S_OUT);
  assign psum_out       = acc;
  assign busy           = (state != S_IDLE);
  assign ovf            = ovf_reg;
  assign dbg_state      = state;

endmodule

// File: tb/tb_pe_psum_accumulator.sv
// Directed bench for pe_psum_accumulator: a table of whole windows plus hand-written
// sequences for backpressure, stray inputs and reset in the middle of a window.
module tb_pe_psum_accumulator;

  localparam int DW = 16;
  localparam int PW = 32;
  localparam int CW = 8;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 start;
  logic [CW-1:0]        filter_len;
  logic                 prod_valid;
  logic signed [2*DW-1:0] product;
  logic                 psum_in_valid;
  logic signed [PW-1:0] psum_in;
  logic                 psum_in_ready;
  logic                 psum_out_valid;
  logic signed [PW-1:0] psum_out;
  logic                 psum_out_ready;
  logic                 busy;
  logic                 ovf;
  logic [1:0]           dbg_state;

  pe_psum_accumulator #(
    .DATA_WIDTH(DW),
    .PSUM_WIDTH(PW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .filter_len    (filter_len),
    .prod_valid    (prod_valid),
    .product       (product),
    .psum_in_valid (psum_in_valid),
    .psum_in       (psum_in),
    .psum_in_ready (psum_in_ready),
    .psum_out_valid(psum_out_valid),
    .psum_out      (psum_out),
    .psum_out_ready(psum_out_ready),
    .busy          (busy),
    .ovf           (ovf),
    .dbg_state     (dbg_state)
  );

  // Scoreboard
  int n_cmp  = 0;
  int n_fail = 0;
  logic [PW-1:0] exp_q[$];

  task automatic check(input string name, input logic signed [PW-1:0] act,
                       input logic signed [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Vector table: one record per window
  typedef struct {
    int                  len;
    logic [3:0][PW-1:0]  p;
    int                  gap;
    bit                  stray;
    logic signed [PW-1:0] pin;
    logic signed [PW-1:0] exp;
    bit                  exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int len, input logic signed [PW-1:0] p0, p1, p2, p3,
                         input int gap, input bit stray, input logic signed [PW-1:0] pin,
                         input logic signed [PW-1:0] exp, input bit exp_ovf);
    vec_t v;
    v.len = len;
    v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
    v.gap = gap; v.stray = stray; v.pin = pin; v.exp = exp; v.exp_ovf = exp_ovf;
    vecs.push_back(v);
  endtask

  // Driver: one full window with immediate output handshake
  task automatic run_vec(input vec_t v);
    exp_q.push_back(v.exp);
    @(negedge clk);
    start = 1'b1;
    filter_len = CW'(v.len);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", PW'(busy), 1);
    check("ovf_clear_on_start", PW'(ovf), 0);
    for (int k = 0; k < v.len; k++) begin
      prod_valid = 1'b0;
      repeat (v.gap) @(negedge clk);
      prod_valid = 1'b1;
      product = $signed(v.p[k]);
      @(negedge clk);
      prod_valid = 1'b0;
    end
    check("psum_in_ready_on_entry", PW'(psum_in_ready), 1);
    check("out_valid_not_early", PW'(psum_out_valid), 0);
    if (v.stray) begin
      prod_valid = 1'b1;
      product = 999;
      repeat (2) @(negedge clk);
      check("psum_in_ready_waits", PW'(psum_in_ready), 1);
    end
    psum_in_valid = 1'b1;
    psum_in = v.pin;
    @(negedge clk);
    psum_in_valid = 1'b0;
    check("out_valid", PW'(psum_out_valid), 1);
    check("psum_in_ready_off", PW'(psum_in_ready), 0);
    check("psum_out", psum_out, $signed(exp_q.pop_front()));
    check("ovf", PW'(ovf), PW'(v.exp_ovf));
    psum_out_ready = 1'b1;
    @(negedge clk);
    psum_out_ready = 1'b0;
    prod_valid = 1'b0;
    check("busy_after_xfer", PW'(busy), 0);
    check("out_valid_after_xfer", PW'(psum_out_valid), 0);
  endtask

  task automatic drive_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; filter_len = '0; prod_valid = 1'b0; product = '0;
    psum_in_valid = 1'b0; psum_in = '0; psum_out_ready = 1'b0;
    @(negedge clk);
    drive_reset();
    check("rst_busy", PW'(busy), 0);
    check("rst_psum_out", psum_out, 0);
    check("rst_out_valid", PW'(psum_out_valid), 0);
    check("rst_in_ready", PW'(psum_in_ready), 0);
    check("rst_ovf", PW'(ovf), 0);
    check("rst_state", PW'(dbg_state), 0);

    //       len  p0            p1            p2   p3  gap stray pin   expected       ovf
    add_vec(3,   100,          -50,          7,   0,  0,  0,    1000, 1057,          0);
    add_vec(4,   2,            3,            4,   5,  2,  1,    500,  514,           0);
    add_vec(2,   32'h4000_0000, 32'h4000_0000, 0, 0,  0,  0,    0,    32'h7fff_ffff, 1);
    add_vec(2,   32'hc000_0000, 32'hc000_0000, 0, 0,  0,  0,    -5,   32'h8000_0000, 1);
    add_vec(0,   0,            0,            0,   0,  0,  0,    -42,  -42,           0);
    add_vec(1,   -7,           0,            0,   0,  0,  0,    3,    -4,            0);
    add_vec(2,   32'h4000_0000, 32'h4000_0000, 0, 0,  1,  0,    -10,  32'h7fff_fff5, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure, with start pulses that must be ignored while in OUT
    @(negedge clk);
    start = 1'b1; filter_len = 8'd1;
    @(negedge clk);
    start = 1'b0;
    prod_valid = 1'b1; product = 10;
    @(negedge clk);
    prod_valid = 1'b0;
    psum_in_valid = 1'b1; psum_in = 5;
    @(negedge clk);
    psum_in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      start = c[0];
      filter_len = 8'd2;
      check("bp_out_valid", PW'(psum_out_valid), 1);
      check("bp_psum_out", psum_out, 15);
      check("bp_state", PW'(dbg_state), 3);
      @(negedge clk);
    end
    check("bp_still_valid", PW'(psum_out_valid), 1);
    start = 1'b1;
    psum_out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    psum_out_ready = 1'b0;
    check("bp_idle_after_xfer", PW'(busy), 0);
    check("bp_valid_dropped", PW'(psum_out_valid), 0);
    @(negedge clk);
    check("bp_start_ignored", PW'(busy), 0);

    // Reset in the middle of a window that has already saturated
    @(negedge clk);
    start = 1'b1; filter_len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      prod_valid = 1'b1; product = 32'h4000_0000;
      @(negedge clk);
    end
    prod_valid = 1'b0;
    check("pre_rst_ovf", PW'(ovf), 1);
    check("pre_rst_busy", PW'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", PW'(busy), 0);
    check("midrst_psum_out", psum_out, 0);
    check("midrst_out_valid", PW'(psum_out_valid), 0);
    check("midrst_in_ready", PW'(psum_in_ready), 0);
    check("midrst_ovf", PW'(ovf), 0);
    begin
      vec_t v;
      v.len = 3; v.p[0] = 1; v.p[1] = 1; v.p[2] = 1; v.p[3] = 0;
      v.gap = 0; v.stray = 0; v.pin = 0; v.exp = 3; v.exp_ovf = 0;
      run_vec(v);
    end

    check("scoreboard_drained", PW'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
